stall_ctrl: RTL and testbench

Hazard and multi-cycle sequencing controller for the five-stage MIPS pipeline. Each cycle it decides whether the D-stage instruction may advance into the D→E pipeline register. It drives the F/D write enables and the `clr` input of the E-stage register, inserting a bubble when the D-stage instruction cannot advance. It also owns the busy counter of the multiply/divide unit, so that HI/LO-dependent instructions wait until the unit has finished.

---
 rtl/stall_ctrl.sv | 102 ++++++++++
 tb/tb_stall_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline; owns the mult/div busy timer.
// Optional stall statistics counter enabled by defining STALL_CTRL_STAT_EN.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4   // must hold max(MULT_CYCLES, DIV_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_writeReg,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_writeReg,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
`ifdef STALL_CTRL_STAT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy
);

  // state | meaning
  // IDLE  | mult/div unit free, cnt == 0
  // BUSY  | mult/div unit running, cnt counts down to 0
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               hz_rs, hz_rt, hz_md, stall;

  always_comb begin
    hz_rs = (D_rs != 5'd0) &&
            (((E_writeReg == D_rs) && (E_tnew > D_tuse_rs)) ||
             ((M_writeReg == D_rs) && (M_tnew > D_tuse_rs)));
    hz_rt = (D_rt != 5'd0) &&
            (((E_writeReg == D_rt) && (E_tnew > D_tuse_rt)) ||
             ((M_writeReg == D_rt) && (M_tnew > D_tuse_rt)));
  end

  assign md_busy = (state == BUSY);
  assign hz_md   = D_is_md && (md_busy || E_md_start);
  assign stall   = hz_rs || hz_rt || hz_md;

  assign F_en  = ~stall;
  assign D_en  = ~stall;
  assign E_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A new mult/div start reloads the timer regardless of any count in progress.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          cnt_next   = E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (E_md_start) begin
          cnt_next   = E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_next = BUSY;
        end else begin
          cnt_next   = cnt - CNT_W'(1);
          state_next = (cnt == CNT_W'(1)) ? IDLE : BUSY;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef STALL_CTRL_STAT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= 32'd0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: combinational hazard table plus
// multi-cycle mult/div/reset sequences (and stall_cnt when STALL_CTRL_STAT_EN is defined).
module tb_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_writeReg, M_writeReg;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_div;
  logic       F_en, D_en, E_clr, md_busy;
`ifdef STALL_CTRL_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .E_writeReg(E_writeReg), .E_tnew(E_tnew),
    .M_writeReg(M_writeReg), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
`ifdef STALL_CTRL_STAT_EN
    .stall_cnt(stall_cnt),
`endif
    .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .md_busy(md_busy)
  );

  typedef struct {
    logic [4:0] rs, rt, e_wr, m_wr;
    logic [1:0] tuse_rs, tuse_rt, e_tnew, m_tnew;
    logic       is_md, start, div;
    logic       exp_stall;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp_stall);
    check({name, ".F_en"},  {31'd0, F_en},  {31'd0, ~exp_stall});
    check({name, ".D_en"},  {31'd0, D_en},  {31'd0, ~exp_stall});
    check({name, ".E_clr"}, {31'd0, E_clr}, {31'd0, exp_stall});
  endtask

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_tuse_rs = 0; D_tuse_rt = 0; D_is_md = 0;
    E_writeReg = 0; E_tnew = 0; M_writeReg = 0; M_tnew = 0;
    E_md_start = 0; E_md_div = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    clear_inputs();
    do_reset();
    #2;
    check("reset.md_busy", {31'd0, md_busy}, 32'd0);
    check_stall("reset", 1'b0);

    //          rs  rt  e_wr m_wr tuse_rs tuse_rt e_tnew m_tnew md st div stall busy
    vecs[0]  = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0};
    vecs[1]  = '{5'd8,  5'd0,  5'd8,  5'd0,  2'd1, 2'd0, 2'd2, 2'd0, 0, 0, 0, 1, 0};
    vecs[2]  = '{5'd8,  5'd0,  5'd8,  5'd0,  2'd1, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0};
    vecs[3]  = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0};
    vecs[4]  = '{5'd0,  5'd9,  5'd0,  5'd9,  2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 1, 0};
    vecs[5]  = '{5'd0,  5'd9,  5'd0,  5'd9,  2'd0, 2'd1, 2'd0, 2'd1, 0, 0, 0, 0, 0};
    vecs[6]  = '{5'd9,  5'd0,  5'd8,  5'd0,  2'd0, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0};
    vecs[7]  = '{5'd8,  5'd0,  5'd8,  5'd0,  2'd3, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0};
    vecs[8]  = '{5'd31, 5'd0,  5'd31, 5'd0,  2'd2, 2'd0, 2'd3, 2'd0, 0, 0, 0, 1, 0};
    vecs[9]  = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd0, 2'd3, 0, 0, 0, 0, 0};
    vecs[10] = '{5'd4,  5'd5,  5'd4,  5'd5,  2'd0, 2'd0, 2'd1, 2'd1, 0, 0, 0, 1, 0};
    vecs[11] = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0};
    vecs[12] = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 1, 0};
    vecs[13] = '{5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 0, 1, 1, 0, 1};

    // One vector per cycle; the last two exercise the mult/div start path.
    for (int i = 0; i < 14; i++) begin
      D_rs = vecs[i].rs; D_rt = vecs[i].rt;
      E_writeReg = vecs[i].e_wr; M_writeReg = vecs[i].m_wr;
      D_tuse_rs = vecs[i].tuse_rs; D_tuse_rt = vecs[i].tuse_rt;
      E_tnew = vecs[i].e_tnew; M_tnew = vecs[i].m_tnew;
      D_is_md = vecs[i].is_md; E_md_start = vecs[i].start; E_md_div = vecs[i].div;
      #2;
      check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
      check($sformatf("vec%0d.md_busy", i), {31'd0, md_busy}, {31'd0, vecs[i].exp_busy});
      step();
    end

    // Mult then mflo: start in cycle t with D_is_md held.
    clear_inputs();
    do_reset();
    E_md_start = 1; E_md_div = 0; D_is_md = 1;
    #2;
    check_stall("mult.t", 1'b1);
    step();
    E_md_start = 0;
    for (int k = 1; k <= 5; k++) begin
      #2;
      check($sformatf("mult.busy t+%0d", k), {31'd0, md_busy}, 32'd1);
      check_stall($sformatf("mult.t+%0d", k), 1'b1);
      step();
    end
    #2;
    check("mult.busy t+6", {31'd0, md_busy}, 32'd0);
    check_stall("mult.t+6", 1'b0);

    // Div with a non-MD instruction in D: busy for exactly 10 cycles, never stalls.
    clear_inputs();
    do_reset();
    E_md_start = 1; E_md_div = 1;
    #2;
    check_stall("div.t", 1'b0);
    step();
    E_md_start = 0;
    busy_cycles = 0;
    for (int k = 1; k <= 14; k++) begin
      #2;
      if (md_busy) busy_cycles++;
      if (k == 10) check("div.busy t+10", {31'd0, md_busy}, 32'd1);
      if (k == 11) check("div.busy t+11", {31'd0, md_busy}, 32'd0);
      if (D_en !== 1'b1) check($sformatf("div.D_en t+%0d", k), {31'd0, D_en}, 32'd1);
      step();
    end
    check("div.busy_cycles", busy_cycles, 32'd10);

    // Reset during cycle t+3 of a div releases a pending MD instruction at t+4.
    clear_inputs();
    do_reset();
    E_md_start = 1; E_md_div = 1;
    step();
    E_md_start = 0; D_is_md = 1;
    step();
    step();
    #2;
    check("rst.busy t+3", {31'd0, md_busy}, 32'd1);
    check_stall("rst.t+3", 1'b1);
    reset = 1;
    step();
    reset = 0;
    #2;
    check("rst.busy t+4", {31'd0, md_busy}, 32'd0);
    check_stall("rst.t+4", 1'b0);

`ifdef STALL_CTRL_STAT_EN
    clear_inputs();
    do_reset();
    #2;
    check("stat.reset", stall_cnt, 32'd0);
    D_rs = 8; E_writeReg = 8; E_tnew = 2; D_tuse_rs = 1;
    for (int k = 0; k < 7; k++) step();
    clear_inputs();
    step();
    step();
    #2;
    check("stat.count7", stall_cnt, 32'd7);
    do_reset();
    #2;
    check("stat.after_reset", stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
